uart_rx_core: RTL and testbench

Parametrised UART receiver with a ready/valid output, the next generation of the team's serial receive path on the Cyclone IV board. Asynchronous serial input is synchronised, start bits are validated at mid-bit, and every bit is sampled at its centre using a programmable baud divider. Word length, parity and stop bits are configurable. Each received word is delivered with framing and parity status through a one-entry holding register; a word lost because the holding register is full raises a sticky overrun flag.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_core.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   function automatic int cnt_width(input int clks);
      return $clog2(clks);
   endfunction

   // data_xor is the XOR of all data bits; returns 1 when the parity bit disagrees
   function automatic logic parity_bad(input logic data_xor, input logic pbit, input parity_t mode);
      logic bad;
      case (mode)
         PAR_ODD:  bad = ((data_xor ^ pbit) != 1'b1);
         PAR_EVEN: bad = ((data_xor ^ pbit) != 1'b0);
         default:  bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser plus falling-edge detector for an idle-high serial line.
module uart_rx_sync (
   input  logic clc,
   input  logic res,
   input  logic rx,
   output logic rx_sync,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // All stages reset high so the idle line never looks like a start edge.
   always_ff @(posedge clc or posedge res) begin
      if (res) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= rx;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rx_sync = sync;
   assign fall    = prev & ~sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling FSM feeding a one-entry ready/valid holding register.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clc,
   input  logic                 res,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 clr_err,
   output logic                 busy
);

   localparam int            CW        = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam parity_t       PMODE     = parity_t'(2'(PARITY));

   logic rx_s;
   logic fall;

   rx_state_t            state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [3:0]           idx, idx_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic                 par_bad, par_bad_nx;
   logic                 stop_bad, stop_bad_nx;
   logic                 done, done_nx;
   logic                 expire;

   uart_rx_sync u_sync (
      .clc     (clc),
      .res     (res),
      .rx      (rx),
      .rx_sync (rx_s),
      .fall    (fall)
   );

   // Counters run down to zero; loading N-1 places the sample N cycles later.
   assign expire = (cnt == CNT_ZERO);

   // FSM state, bit timing, shifter and per-frame status registers.
   always_ff @(posedge clc or posedge res) begin
      if (res) begin
         state    <= ST_IDLE;
         cnt      <= HALF_LOAD;
         idx      <= 4'd0;
         shreg    <= '0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         idx      <= idx_nx;
         shreg    <= shreg_nx;
         par_bad  <= par_bad_nx;
         stop_bad <= stop_bad_nx;
         done     <= done_nx;
         busy     <= (state_nx != ST_IDLE);
      end
   end

   // Next-state logic; each expiry is one centred sample of the line.
   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      shreg_nx    = shreg;
      par_bad_nx  = par_bad;
      stop_bad_nx = stop_bad;
      done_nx     = 1'b0;
      if (expire) begin
         cnt_nx = BIT_LOAD;
      end else begin
         cnt_nx = cnt - CNT_ONE;
      end
      case (state)
         ST_IDLE: begin
            cnt_nx = HALF_LOAD;
            if (fall) begin
               state_nx = ST_START;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_START: begin
            if (!expire) begin
               state_nx = ST_START;
            end else if (rx_s) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx    = ST_DATA;
               idx_nx      = 4'd0;
               par_bad_nx  = 1'b0;
               stop_bad_nx = 1'b0;
            end
         end
         ST_DATA: begin
            if (expire) begin
               shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
               if (idx == LAST_DATA) begin
                  idx_nx   = 4'd0;
                  state_nx = (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
               end else begin
                  idx_nx = idx + 4'd1;
               end
            end else begin
               state_nx = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (expire) begin
               par_bad_nx = parity_bad(^shreg, rx_s, PMODE);
               idx_nx     = 4'd0;
               state_nx   = ST_STOP;
            end else begin
               state_nx = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (expire) begin
               stop_bad_nx = stop_bad | ~rx_s;
               if (idx == LAST_STOP) begin
                  idx_nx   = 4'd0;
                  done_nx  = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  idx_nx = idx + 4'd1;
               end
            end else begin
               state_nx = ST_STOP;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Holding register: a completion may reload it in the same cycle it is accepted.
   always_ff @(posedge clc or posedge res) begin
      if (res) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (done && (!rx_valid || rx_ready)) begin
            rx_data    <= shreg;
            parity_err <= par_bad;
            frame_err  <= stop_bad;
            rx_valid   <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (done && rx_valid && !rx_ready) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: three instances (8N1, 8E1, 7N2) at 16 clocks per bit.
module tb_uart_rx_core;

   logic       clc = 1'b0;
   logic       res;
   logic [2:0] rx_l;
   logic [2:0] rdy;
   logic [2:0] clr;
   logic [2:0] vld, pe, fe, ov, bsy;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic [8:0] dat [3];

   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         rises [3];
   int         rise_cyc [3];
   int         fall_cyc [3];
   int         busy_cnt [3];
   int         start_cyc [3];
   logic [8:0] rdat [3];
   logic [2:0] rpe = 3'b000;
   logic [2:0] rfe = 3'b000;
   logic [2:0] vprev = 3'b000;

   uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clc(clc), .res(res), .rx(rx_l[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
      .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .clr_err(clr[0]), .busy(bsy[0]));

   uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
      .clc(clc), .res(res), .rx(rx_l[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
      .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .clr_err(clr[1]), .busy(bsy[1]));

   uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
      .clc(clc), .res(res), .rx(rx_l[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
      .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .clr_err(clr[2]), .busy(bsy[2]));

   assign dat[0] = {1'b0, d0};
   assign dat[1] = {1'b0, d1};
   assign dat[2] = {2'b00, d2};

   initial forever #5 clc = ~clc;

   always @(posedge clc) cyc <= cyc + 1;

   // Record every rx_valid rise/fall and busy occupancy per instance.
   always @(negedge clc) begin
      for (int i = 0; i < 3; i++) begin
         if (vld[i] && !vprev[i]) begin
            rises[i]    <= rises[i] + 1;
            rise_cyc[i] <= cyc;
            rdat[i]     <= dat[i];
            rpe[i]      <= pe[i];
            rfe[i]      <= fe[i];
         end
         if (!vld[i] && vprev[i]) fall_cyc[i] <= cyc;
         if (bsy[i]) busy_cnt[i] <= busy_cnt[i] + 1;
      end
      vprev <= vld;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clc);
   endtask

   // bits[0] is the start bit; each bit lasts 16 clocks
   task automatic send(input int i, input logic [15:0] bits, input int n);
      @(negedge clc);
      start_cyc[i] = cyc;
      for (int k = 0; k < n; k++) begin
         rx_l[i] = bits[k];
         repeat (16) @(negedge clc);
      end
      rx_l[i] = 1'b1;
   endtask

   int r0, b0, r2;

   initial begin
      rx_l = 3'b111;
      rdy  = 3'b111;
      clr  = 3'b000;
      res  = 1'b1;
      wait_cyc(3);
      res = 1'b0;
      wait_cyc(1);
      check("rst_valid", vld, 3'b000);
      check("rst_busy", bsy, 3'b000);
      check("rst_overrun", ov, 3'b000);
      check("rst_frame", fe, 3'b000);
      check("rst_parity", pe, 3'b000);
      check("rst_data", {d0, d1, 1'b0, d2}, 32'h0);

      // 8N1 0xA5 with ready high; rise = start + 3 + 8 + 144 + 1
      r0 = rises[0];
      send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
      wait_cyc(20);
      check("a5_count", rises[0] - r0, 1);
      check("a5_data", rdat[0], 9'h0A5);
      check("a5_perr", rpe[0], 1'b0);
      check("a5_ferr", rfe[0], 1'b0);
      check("a5_rise", rise_cyc[0] - start_cyc[0], 156);
      check("a5_drop", fall_cyc[0] - rise_cyc[0], 1);

      // 4-clock glitch: busy for exactly H = 8 cycles, no word
      r0 = rises[0];
      b0 = busy_cnt[0];
      @(negedge clc);
      rx_l[0] = 1'b0;
      wait_cyc(4);
      rx_l[0] = 1'b1;
      wait_cyc(30);
      check("glitch_busy_cycles", busy_cnt[0] - b0, 8);
      check("glitch_idle", bsy[0], 1'b0);
      check("glitch_no_word", rises[0] - r0, 0);
      send(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
      wait_cyc(20);
      check("3c_count", rises[0] - r0, 1);
      check("3c_data", rdat[0], 9'h03C);

      // even parity: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right
      send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      wait_cyc(20);
      check("par0_data", rdat[1], 9'h007);
      check("par0_perr", rpe[1], 1'b1);
      check("par0_ferr", rfe[1], 1'b0);
      check("par0_rise", rise_cyc[1] - start_cyc[1], 172);
      send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      wait_cyc(20);
      check("par1_data", rdat[1], 9'h007);
      check("par1_perr", rpe[1], 1'b0);

      // stop bit 0, then a 20-bit break
      send(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
      wait_cyc(20);
      check("stop0_data", rdat[0], 9'h055);
      check("stop0_ferr", rfe[0], 1'b1);
      r0 = rises[0];
      @(negedge clc);
      rx_l[0] = 1'b0;
      wait_cyc(320);
      rx_l[0] = 1'b1;
      wait_cyc(40);
      check("break_count", rises[0] - r0, 1);
      check("break_data", rdat[0], 9'h000);
      check("break_ferr", rfe[0], 1'b1);
      send(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
      wait_cyc(20);
      check("after_break_data", rdat[0], 9'h096);
      check("after_break_ferr", rfe[0], 1'b0);

      // overrun: two frames with ready low
      rdy[0] = 1'b0;
      r0 = rises[0];
      send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
      send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
      wait_cyc(20);
      check("ovr_flag", ov[0], 1'b1);
      check("ovr_valid", vld[0], 1'b1);
      check("ovr_held", d0, 8'h11);
      @(negedge clc);
      rdy[0] = 1'b1;
      @(negedge clc);
      rdy[0] = 1'b0;
      wait_cyc(5);
      check("ovr_taken", vld[0], 1'b0);
      check("ovr_one_word", rises[0] - r0, 1);
      check("ovr_sticky", ov[0], 1'b1);
      @(negedge clc);
      clr[0] = 1'b1;
      @(negedge clc);
      clr[0] = 1'b0;
      check("ovr_clear", ov[0], 1'b0);
      rdy[0] = 1'b1;

      // 7N2: hold a word, then reset in the middle of data bit 3
      rdy[2] = 1'b0;
      send(2, {6'b0, 2'b11, 7'h55, 1'b0}, 10);
      wait_cyc(20);
      check("7n2_pre_valid", vld[2], 1'b1);
      check("7n2_pre_data", d2, 7'h55);
      fork
         send(2, {6'b0, 2'b11, 7'h78, 1'b0}, 10);
         begin
            wait_cyc(16 * 4 + 8);
            check("res_pre_busy", bsy[2], 1'b1);
            res = 1'b1;
            #1;
            check("res_data", d2, 7'h00);
            check("res_valid", vld[2], 1'b0);
            check("res_busy", bsy[2], 1'b0);
            check("res_flags", {pe[2], fe[2], ov[2]}, 3'b000);
            @(negedge clc);
            res = 1'b0;
         end
      join
      r2 = rises[2];
      wait_cyc(40);
      check("res_no_word", rises[2] - r2, 0);
      rdy[2] = 1'b1;
      send(2, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
      wait_cyc(20);
      check("81_count", rises[2] - r2, 1);
      check("81_data", rdat[2], 9'h001);
      check("81_ferr", rfe[2], 1'b0);
      check("81_rise", rise_cyc[2] - start_cyc[2], 156);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
